// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//  - opcode constants for the supported instruction subset
//  - ALUOp / ALUSrcB / PCSource mux codes
//  - 4-bit FSM state enum and the ID-stage dispatch helper
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_LW   = 4'd6,
    S_MEM_WR  = 4'd7,
    S_EX_BR   = 4'd8,
    S_EX_J    = 4'd9,
    S_EX_I    = 4'd10,
    S_WB_I    = 4'd11
  } state_t;

  // Successor of ID for a given opcode. Returning S_IF marks the opcode
  // as unsupported, which is also how illegal_op is derived.
  function automatic state_t id_next(input logic [5:0] op, input logic bne_en);
    state_t nxt;
    case (op)
      OP_RTYPE:       nxt = S_EX_R;
      OP_LW, OP_SW:   nxt = S_EX_ADDR;
      OP_BEQ:         nxt = S_EX_BR;
      OP_BNE:         nxt = bne_en ? S_EX_BR : S_IF;
      OP_J:           nxt = S_EX_J;
      OP_ADDI,
      OP_ANDI:        nxt = S_EX_I;
      default:        nxt = S_IF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctl_decode.sv
// Combinational control decode for the multi-cycle MIPS controller.
// Turns the current state (plus mem_ready, the live opcode for the ID
// stage and the opcode captured in ID) into datapath controls.
//  in : reset, state, mem_ready, op (live), op_q (captured in ID)
//  out: datapath strobes and mux selects, illegal_op, retire
//       (retire = this is the last cycle of an instruction)
module multicycle_ctl_decode
  import mips_pkg::*;
#(
  parameter int BNE_EN = 1
) (
  input  logic       reset,
  input  state_t     state,
  input  logic       mem_ready,
  input  logic [5:0] op,
  input  logic [5:0] op_q,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       retire
);

  localparam logic BNE_ON = (BNE_EN != 0);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    retire      = 1'b0;

    case (state)
      S_IF: begin
        // PC+4 and IR load commit only once the fetch completes
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_ID: begin
        // precompute branch target into ALUOut while decoding
        ALUSrcB    = SRCB_IMM_SH2;
        illegal_op = (id_next(op, BNE_ON) == S_IF);
      end
      S_EX_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_EX_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_WB_LW: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      S_EX_BR: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNe    = (op_q == OP_BNE);
        retire      = 1'b1;
      end
      S_EX_J: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        retire   = 1'b1;
      end
      S_EX_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (op_q == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase

    // reset can land mid-instruction; no strobe may leak while it is high
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctl.sv
// Multi-cycle MIPS control FSM. Sequences the shared ALU/memory datapath
// through IF/ID/EX/MEM/WB, stalling on mem_ready, and counts cycles and
// retired instructions.
//  in : clk, reset (async, active-high), op, mem_ready
//  out: datapath controls (PCWrite..PCSource), state (debug), illegal_op,
//       cycle_cnt, retire_cnt
//
//  state   | meaning
//  IF      | fetch at PC, PC+4; wait for mem_ready
//  ID      | decode op, branch target into ALUOut
//  EX_R    | R-type ALU op
//  WB_R    | write rd from ALUOut
//  EX_ADDR | lw/sw effective address
//  MEM_RD  | load access, wait for mem_ready
//  WB_LW   | write rt from MDR
//  MEM_WR  | store access, wait for mem_ready
//  EX_BR   | beq/bne compare and conditional PC load
//  EX_J    | jump
//  EX_I    | addi/andi ALU op
//  WB_I    | write rt from ALUOut
module multicycle_ctl
  import mips_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int BNE_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic BNE_ON = (BNE_EN != 0);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic       retire;

  // op is only trusted in ID; later stages use this captured copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= op;
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:      state_d = mem_ready ? S_ID : S_IF;
      S_ID:      state_d = id_next(op, BNE_ON);
      S_EX_R:    state_d = S_WB_R;
      S_WB_R:    state_d = S_IF;
      S_EX_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = mem_ready ? S_WB_LW : S_MEM_RD;
      S_WB_LW:   state_d = S_IF;
      S_MEM_WR:  state_d = mem_ready ? S_IF : S_MEM_WR;
      S_EX_BR:   state_d = S_IF;
      S_EX_J:    state_d = S_IF;
      S_EX_I:    state_d = S_WB_I;
      S_WB_I:    state_d = S_IF;
      default:   state_d = S_IF;
    endcase
  end

  multicycle_ctl_decode #(
    .BNE_EN (BNE_EN)
  ) u_decode (
    .reset       (reset),
    .state       (state_q),
    .mem_ready   (mem_ready),
    .op          (op),
    .op_q        (op_q),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .retire      (retire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctl.sv
module tb_multicycle_ctl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic mem_ready = 1'b0;

  logic PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [31:0] cycle_cnt, retire_cnt;

  logic PCWrite4, PCWriteCond4, BranchNe4, IorD4, MemRead4, MemWrite4, IRWrite4;
  logic MemtoReg4, RegDst4, RegWrite4, ALUSrcA4, illegal_op4;
  logic [1:0] ALUSrcB4, ALUOp4, PCSource4;
  logic [3:0] state4;
  logic [3:0] cycle_cnt4, retire_cnt4;

  int vecs = 0;
  int errs = 0;
  int exp_cyc = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctl #(.CNT_W(32), .BNE_EN(1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  multicycle_ctl #(.CNT_W(4), .BNE_EN(0)) dut4 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .BranchNe(BranchNe4),
    .IorD(IorD4), .MemRead(MemRead4), .MemWrite(MemWrite4), .IRWrite(IRWrite4),
    .MemtoReg(MemtoReg4), .RegDst(RegDst4), .RegWrite(RegWrite4),
    .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4), .PCSource(PCSource4),
    .state(state4), .illegal_op(illegal_op4),
    .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite}
  logic [8:0] strb;
  assign strb = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite};
  // {ALUSrcA,ALUSrcB,ALUOp,PCSource,BranchNe}
  logic [7:0] ctl;
  assign ctl = {ALUSrcA, ALUSrcB, ALUOp, PCSource, BranchNe};

  // one clock cycle: inputs change at negedge, outputs sampled 1 time unit later
  task automatic cyc(input logic [5:0] o, input logic mr);
    @(negedge clk);
    op = o;
    mem_ready = mr;
    #1;
    exp_cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if (state !== 4'd0 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errs++;
      $display("FAIL reset_state state=%0d cyc=%0d ret=%0d want 0/0/0", state, cycle_cnt, retire_cnt);
    end
    vecs++;
    if (strb !== 9'd0 || illegal_op !== 1'b0) begin
      errs++;
      $display("FAIL reset_strobes got %b ill=%b want 000000000 ill=0", strb, illegal_op);
    end
    reset = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic test_add();
    logic [3:0] st_e [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [8:0] sb_e [4] = '{9'b100101000, 9'b000000000, 9'b000000000, 9'b000000011};
    logic [7:0] ct_e [4] = '{8'b0_01_00_00_0, 8'b0_11_00_00_0, 8'b1_00_10_00_0, 8'b0_00_00_00_0};
    for (int i = 0; i < 4; i++) begin
      cyc(OP_RTYPE, 1'b1);
      vecs++;
      if (state !== st_e[i] || strb !== sb_e[i] || ctl !== ct_e[i]) begin
        errs++;
        $display("FAIL add_c%0d st=%0d strb=%b ctl=%b want st=%0d strb=%b ctl=%b",
                 i + 1, state, strb, ctl, st_e[i], sb_e[i], ct_e[i]);
      end
      vecs++;
      if (retire_cnt !== 32'(exp_ret)) begin
        errs++;
        $display("FAIL add_ret_c%0d got %0d want %0d", i + 1, retire_cnt, exp_ret);
      end
    end
    exp_ret++;
    cyc(OP_RTYPE, 1'b0);
    vecs++;
    if (state !== 4'd0 || retire_cnt !== 32'(exp_ret) || cycle_cnt !== 32'(exp_cyc)) begin
      errs++;
      $display("FAIL add_done st=%0d ret=%0d cyc=%0d want 0/%0d/%0d", state, retire_cnt, cycle_cnt, exp_ret, exp_cyc);
    end
  endtask

  task automatic test_lw();
    // op driven in EX_ADDR onward is sw: must be ignored after ID
    logic [5:0] op_v [8] = '{OP_LW, OP_LW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    logic       mr_v [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] st_e [8] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
    logic [8:0] sb_e [8] = '{9'b100101000, 9'b0, 9'b0, 9'b001100000, 9'b001100000,
                             9'b001100000, 9'b001100000, 9'b000000101};
    for (int i = 0; i < 8; i++) begin
      cyc(op_v[i], mr_v[i]);
      vecs++;
      if (state !== st_e[i] || strb !== sb_e[i]) begin
        errs++;
        $display("FAIL lw_c%0d st=%0d strb=%b want st=%0d strb=%b", i + 1, state, strb, st_e[i], sb_e[i]);
      end
    end
    exp_ret++;
    cyc(OP_LW, 1'b0);
    vecs++;
    if (state !== 4'd0 || retire_cnt !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL lw_done st=%0d ret=%0d want 0/%0d", state, retire_cnt, exp_ret);
    end
  endtask

  task automatic test_bne();
    cyc(OP_BNE, 1'b1);
    cyc(OP_BNE, 1'b1);
    vecs++;
    if (state !== 4'd1 || illegal_op !== 1'b0) begin
      errs++;
      $display("FAIL bne_id st=%0d ill=%b want 1/0", state, illegal_op);
    end
    vecs++;
    if (illegal_op4 !== 1'b1) begin
      errs++;
      $display("FAIL bne_disabled_ill got %b want 1", illegal_op4);
    end
    cyc(OP_BNE, 1'b1);
    vecs++;
    if (state !== 4'd8 || strb !== 9'b010000000 || ctl !== 8'b1_00_01_01_1) begin
      errs++;
      $display("FAIL bne_ex st=%0d strb=%b ctl=%b want 8 010000000 10001011", state, strb, ctl);
    end
    vecs++;
    if (state4 !== 4'd0) begin
      errs++;
      $display("FAIL bne_disabled_next got %0d want 0", state4);
    end
    exp_ret++;
    cyc(OP_BNE, 1'b0);
    vecs++;
    if (state !== 4'd0 || retire_cnt !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL bne_done st=%0d ret=%0d want 0/%0d", state, retire_cnt, exp_ret);
    end
  endtask

  task automatic test_illegal();
    cyc(6'b111111, 1'b1);
    cyc(6'b111111, 1'b1);
    vecs++;
    if (state !== 4'd1 || illegal_op !== 1'b1 || strb !== 9'd0) begin
      errs++;
      $display("FAIL ill_id st=%0d ill=%b strb=%b want 1/1/000000000", state, illegal_op, strb);
    end
    cyc(6'b111111, 1'b0);
    vecs++;
    if (state !== 4'd0 || illegal_op !== 1'b0 || retire_cnt !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL ill_next st=%0d ill=%b ret=%0d want 0/0/%0d", state, illegal_op, retire_cnt, exp_ret);
    end
  endtask

  task automatic test_sw_reset();
    // complete store with one wait cycle
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b0);
    vecs++;
    if (state !== 4'd7 || strb !== 9'b001010000) begin
      errs++;
      $display("FAIL sw_wait st=%0d strb=%b want 7 001010000", state, strb);
    end
    cyc(OP_SW, 1'b1);
    exp_ret++;
    cyc(OP_SW, 1'b0);
    vecs++;
    if (state !== 4'd0 || retire_cnt !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL sw_done st=%0d ret=%0d want 0/%0d", state, retire_cnt, exp_ret);
    end
    // second store, aborted by reset in MEM_WR
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b1);
    cyc(OP_SW, 1'b0);
    vecs++;
    if (MemWrite !== 1'b1) begin
      errs++;
      $display("FAIL sw2_memwrite got %b want 1", MemWrite);
    end
    reset = 1'b1;
    #1;
    vecs++;
    if (MemWrite !== 1'b0 || strb !== 9'd0 || state !== 4'd0 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errs++;
      $display("FAIL sw_abort mw=%b strb=%b st=%0d cyc=%0d ret=%0d want 0/0/0/0/0",
               MemWrite, strb, state, cycle_cnt, retire_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
    #1;
    vecs++;
    if (state !== 4'd0 || cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errs++;
      $display("FAIL sw_release st=%0d cyc=%0d ret=%0d want 0/0/0", state, cycle_cnt, retire_cnt);
    end
  endtask

  task automatic test_j_wrap();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(OP_J, 1'b1);
      vecs++;
      if (retire_cnt4 !== 4'(k)) begin
        errs++;
        $display("FAIL j_ret4_%0d got %0d want %0d", k, retire_cnt4, k);
      end
      cyc(OP_J, 1'b1);
      cyc(OP_J, 1'b1);
      vecs++;
      if (state !== 4'd9 || strb !== 9'b100000000 || ctl !== 8'b0_00_00_10_0) begin
        errs++;
        $display("FAIL j_ex_%0d st=%0d strb=%b ctl=%b want 9 100000000 00000100", k, state, strb, ctl);
      end
      exp_ret++;
    end
    cyc(OP_J, 1'b0);
    vecs++;
    if (retire_cnt4 !== 4'd0 || retire_cnt !== 32'd16) begin
      errs++;
      $display("FAIL j_wrap_ret r4=%0d r=%0d want 0/16", retire_cnt4, retire_cnt);
    end
    vecs++;
    if (cycle_cnt4 !== 4'd1 || cycle_cnt !== 32'd49) begin
      errs++;
      $display("FAIL j_wrap_cyc c4=%0d c=%0d want 1/49", cycle_cnt4, cycle_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_bne();
    test_illegal();
    test_sw_reset();
    test_j_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
